spi_rgb_regs: RTL and testbench

Register front-end for the SPI-to-RGB design. It sits between the SPI byte receiver and the LED colour-cycle channels. It parses framed command bytes and holds the control registers. It drives the cycle speed, the cycle restart pulse, the auto/static mode select and the static RGB levels that the LED path consumes.

---
 rtl/spi_rgb_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_rgb_regs.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rgb_regs.sv
// spi_rgb_regs -- register front-end between the SPI byte receiver and the
// LED colour-cycle channels.
//
// It parses framed command bytes and holds the control registers.
// A frame is every i_rx_valid byte seen while i_sel is high.
//
// Frame layout:
//   byte 0      : command. 0x01 = write, 0x02 = read, 0x03 = restart.
//   byte 1      : register address [2:0].
//   bytes 2..   : data. The address post-increments and wraps 7 -> 0.
//
// Register map:
//   0     : CTRL {hold, static}
//   1..3  : SPEED[7:0], [15:8], [19:16]
//   4..6  : R, G, B
//   7     : ID (read-only)
//
// SPEED writes land in a shadow. The shadow is committed to o_speed at frame
// end, and the commit also pulses o_cycle_rst.
//
// Configuration macro: SPI_RGB_REGS_READBACK_EN.
//   Defined   : enables the read command and the o_tx_data readback path.
//   Undefined : 0x02 is an unknown command and o_tx_data is tied to 0.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_sel        synchronised chip select, high = frame active
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_speed      committed divider terminal count
//   o_cycle_rst  one-cycle restart pulse to the cycle channels
//   o_static     1 = static colour, 0 = auto colour cycle
//   o_hold       1 = hold the cycle channels in reset
//   o_r/o_g/o_b  static colour levels
//   o_tx_data    readback byte for the SPI transmitter
//   o_err        one-cycle pulse on an unknown command
module spi_rgb_regs #(
   parameter logic [19:0] DEFAULT_SPEED = 20'd99999,
   parameter logic [7:0]  ID_VALUE      = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sel,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [19:0] o_speed,
   output logic        o_cycle_rst,
   output logic        o_static,
   output logic        o_hold,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic [7:0]  o_tx_data,
   output logic        o_err
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_WDATA  = 3'd3;
   localparam logic [2:0] ST_RDATA  = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;

   logic [2:0]  state;
   logic [2:0]  cur_state;
   logic        sel_q;
   logic [2:0]  addr;
   logic [19:0] shadow;
   logic        dirty;

`ifdef SPI_RGB_REGS_READBACK_EN
   logic        is_read;
   logic [7:0]  tx_data;

   assign o_tx_data = tx_data;

   // Readback mux. SPEED addresses return the committed value, not the shadow.
   function automatic logic [7:0] rd_reg(input logic [2:0] a);
      case (a)
         3'd0:    rd_reg = {6'd0, o_hold, o_static};
         3'd1:    rd_reg = o_speed[7:0];
         3'd2:    rd_reg = o_speed[15:8];
         3'd3:    rd_reg = {4'd0, o_speed[19:16]};
         3'd4:    rd_reg = o_r;
         3'd5:    rd_reg = o_g;
         3'd6:    rd_reg = o_b;
         default: rd_reg = ID_VALUE;
      endcase
   endfunction
`else
   assign o_tx_data = 8'h00;
`endif

   // Effective state: a byte arriving in the first cycle of a frame (still
   // IDLE because i_sel only just rose) is treated as the command byte.
   always_comb begin
      cur_state = state;
      if (state == ST_IDLE) begin
         cur_state = ST_CMD;
      end else begin
         cur_state = state;
      end
   end

   // Frame parser, register file, speed shadow/commit and pulse outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         sel_q       <= 1'b0;
         addr        <= 3'd0;
         shadow      <= DEFAULT_SPEED;
         dirty       <= 1'b0;
         o_speed     <= DEFAULT_SPEED;
         o_cycle_rst <= 1'b0;
         o_static    <= 1'b0;
         o_hold      <= 1'b0;
         o_r         <= 8'h00;
         o_g         <= 8'h00;
         o_b         <= 8'h00;
         o_err       <= 1'b0;
`ifdef SPI_RGB_REGS_READBACK_EN
         is_read     <= 1'b0;
         tx_data     <= 8'h00;
`endif
      end else begin
         sel_q       <= i_sel;
         o_err       <= 1'b0;
         o_cycle_rst <= 1'b0;
         if (!i_sel) begin
            // Frame end (or no frame): a byte in this cycle is dropped.
            state <= ST_IDLE;
            dirty <= 1'b0;
            if (sel_q && dirty) begin
               o_speed     <= shadow;
               o_cycle_rst <= 1'b1;
            end
`ifdef SPI_RGB_REGS_READBACK_EN
            tx_data <= 8'h00;
`endif
         end else if (i_rx_valid) begin
            case (cur_state)
               ST_CMD: begin
                  case (i_rx_data)
                     8'h01: begin
                        state <= ST_ADDR;
`ifdef SPI_RGB_REGS_READBACK_EN
                        is_read <= 1'b0;
`endif
                     end
`ifdef SPI_RGB_REGS_READBACK_EN
                     8'h02: begin
                        state   <= ST_ADDR;
                        is_read <= 1'b1;
                     end
`endif
                     8'h03: begin
                        state       <= ST_IGNORE;
                        o_cycle_rst <= 1'b1;
                     end
                     default: begin
                        state <= ST_IGNORE;
                        o_err <= 1'b1;
                     end
                  endcase
               end
               ST_ADDR: begin
`ifdef SPI_RGB_REGS_READBACK_EN
                  if (is_read) begin
                     // Preload reg[addr]; the next byte reads reg[addr+1].
                     state   <= ST_RDATA;
                     tx_data <= rd_reg(i_rx_data[2:0]);
                     addr    <= i_rx_data[2:0] + 3'd1;
                  end else begin
                     state <= ST_WDATA;
                     addr  <= i_rx_data[2:0];
                  end
`else
                  state <= ST_WDATA;
                  addr  <= i_rx_data[2:0];
`endif
               end
               ST_WDATA: begin
                  addr <= addr + 3'd1;
                  case (addr)
                     3'd0: begin
                        o_static <= i_rx_data[0];
                        o_hold   <= i_rx_data[1];
                     end
                     3'd1: begin
                        shadow[7:0] <= i_rx_data;
                        dirty       <= 1'b1;
                     end
                     3'd2: begin
                        shadow[15:8] <= i_rx_data;
                        dirty        <= 1'b1;
                     end
                     3'd3: begin
                        shadow[19:16] <= i_rx_data[3:0];
                        dirty         <= 1'b1;
                     end
                     3'd4:    o_r <= i_rx_data;
                     3'd5:    o_g <= i_rx_data;
                     3'd6:    o_b <= i_rx_data;
                     default: addr <= addr + 3'd1;  // ID is read-only
                  endcase
               end
`ifdef SPI_RGB_REGS_READBACK_EN
               ST_RDATA: begin
                  tx_data <= rd_reg(addr);
                  addr    <= addr + 3'd1;
               end
`endif
               default: state <= ST_IGNORE;
            endcase
         end else begin
            state <= cur_state;
         end
      end
   end

endmodule

// File: tb/tb_spi_rgb_regs.sv
// Self-checking bench for spi_rgb_regs.
//
// Framing parser reference model: byte index 0 is the command, index 1 is the
// base address, and index k >= 2 addresses base + k - 2 (write) or
// base + k - 1 (read readback), modulo 8.
module tb_spi_rgb_regs;

`ifdef SPI_RGB_REGS_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam logic [19:0] DEF_SPEED = 20'd99999;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [19:0] speed;
   logic        cycle_rst, stat, hold, err;
   logic [7:0]  r, g, b, tx_data;

   spi_rgb_regs dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_rx_data(rx_data),
      .i_rx_valid(rx_valid), .o_speed(speed), .o_cycle_rst(cycle_rst),
      .o_static(stat), .o_hold(hold), .o_r(r), .o_g(g), .o_b(b),
      .o_tx_data(tx_data), .o_err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  r_m, g_m, b_m, tx_m;
   logic [1:0]  ctrl_m;
   logic [19:0] speed_m, shadow_m;
   bit          dirty_m, err_m, crst_m;
   logic [7:0]  cmd_m;
   int          base_m, idx_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("speed", 32'(speed), 32'(speed_m));
      chk("cycle_rst", 32'(cycle_rst), 32'(crst_m));
      chk("err", 32'(err), 32'(err_m));
      chk("static", 32'(stat), 32'(ctrl_m[0]));
      chk("hold", 32'(hold), 32'(ctrl_m[1]));
      chk("r", 32'(r), 32'(r_m));
      chk("g", 32'(g), 32'(g_m));
      chk("b", 32'(b), 32'(b_m));
      chk("tx_data", 32'(tx_data), 32'(tx_m));
   endtask

   task automatic model_reset();
      r_m = 8'h00; g_m = 8'h00; b_m = 8'h00; tx_m = 8'h00; ctrl_m = 2'd0;
      speed_m = DEF_SPEED; shadow_m = DEF_SPEED; dirty_m = 1'b0;
      err_m = 1'b0; crst_m = 1'b0; cmd_m = 8'h00; base_m = 0; idx_m = 0;
   endtask

   function automatic logic [7:0] read_m(input int a);
      case (a)
         0: return {6'd0, ctrl_m};
         1: return speed_m[7:0];
         2: return speed_m[15:8];
         3: return {4'd0, speed_m[19:16]};
         4: return r_m;
         5: return g_m;
         6: return b_m;
         default: return 8'hA5;
      endcase
   endfunction

   task automatic write_m(input int a, input logic [7:0] d);
      case (a)
         0: ctrl_m = d[1:0];
         1: begin shadow_m[7:0] = d; dirty_m = 1'b1; end
         2: begin shadow_m[15:8] = d; dirty_m = 1'b1; end
         3: begin shadow_m[19:16] = d[3:0]; dirty_m = 1'b1; end
         4: r_m = d;
         5: g_m = d;
         6: b_m = d;
         default: ;
      endcase
   endtask

   task automatic model_byte(input logic [7:0] d);
      bit wr, rd;
      err_m = 1'b0; crst_m = 1'b0;
      wr = (cmd_m == 8'h01);
      rd = (cmd_m == 8'h02) && RB;
      if (idx_m == 0) begin
         cmd_m = d;
         if (d == 8'h03) crst_m = 1'b1;
         else if (!(d == 8'h01 || (d == 8'h02 && RB))) err_m = 1'b1;
      end else if (idx_m == 1 && (wr || rd)) begin
         base_m = int'(d[2:0]);
         if (rd) tx_m = read_m(base_m);
      end else if (wr) begin
         write_m((base_m + idx_m - 2) % 8, d);
      end else if (rd) begin
         tx_m = read_m((base_m + idx_m - 1) % 8);
      end
      idx_m++;
   endtask

   // Send one frame byte, optionally after an idle in-frame cycle.
   task automatic send_byte(input logic [7:0] d, input bit gap);
      if (gap) begin
         @(negedge clk); sel = 1'b1; rx_valid = 1'b0;
         @(posedge clk); #1;
         err_m = 1'b0; crst_m = 1'b0;
         check_all();
      end
      @(negedge clk); sel = 1'b1; rx_valid = 1'b1; rx_data = d;
      @(posedge clk); #1; rx_valid = 1'b0;
      model_byte(d);
      check_all();
   endtask

   // Deassert select (optionally with a colliding byte that must be dropped).
   task automatic end_frame(input bit with_valid, input logic [7:0] d);
      @(negedge clk); sel = 1'b0; rx_valid = with_valid; rx_data = d;
      @(posedge clk); #1; rx_valid = 1'b0;
      err_m = 1'b0; crst_m = 1'b0;
      if (dirty_m) begin speed_m = shadow_m; crst_m = 1'b1; end
      dirty_m = 1'b0; tx_m = 8'h00; idx_m = 0;
      check_all();
      @(posedge clk); #1;
      crst_m = 1'b0;
      check_all();
   endtask

   task automatic frame(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
      end_frame(1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] q[$];
      model_reset();
      // Reset state
      repeat (3) @(posedge clk);
      #1 check_all();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1 check_all();

      // RGB write, CTRL static
      frame('{8'h01, 8'h04, 8'h11, 8'h22, 8'h33});
      frame('{8'h01, 8'h00, 8'h01});
      // SPEED commit at frame end
      frame('{8'h01, 8'h01, 8'h40, 8'h0D, 8'h03});
      chk("speed_0x30D40", 32'(speed), 32'h30D40);
      // Write wrapping through ID to CTRL
      frame('{8'h01, 8'h06, 8'hAA, 8'hBB, 8'hCC});
      // Read through ID and wrap
      frame('{8'h02, 8'h07, 8'h00, 8'h00});
      // Restart and unknown command, trailing bytes ignored
      frame('{8'h03, 8'h04, 8'h99, 8'h98});
      frame('{8'h7F, 8'h01, 8'h04, 8'h55});
      // Byte colliding with frame end is dropped
      send_byte(8'h01, 1'b1);
      send_byte(8'h04, 1'b0);
      end_frame(1'b1, 8'h77);

      // Reset mid-frame after 01 01 FF
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hFF, 1'b0);
      @(negedge clk); rst_n = 1'b0; sel = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1 check_all();
      frame('{8'h01, 8'h04, 8'h12});

      // Randomized frames
      for (int f = 0; f < 60; f++) begin
         int pick;
         int len;
         q.delete();
         pick = $urandom_range(0, 9);
         if (pick < 4)      q.push_back(8'h01);
         else if (pick < 7) q.push_back(8'h02);
         else if (pick < 8) q.push_back(8'h03);
         else               q.push_back(8'($urandom));
         len = $urandom_range(0, 9);
         for (int k = 0; k < len; k++) q.push_back(8'($urandom));
         foreach (q[i]) send_byte(q[i], bit'($urandom_range(0, 3) == 0));
         end_frame(bit'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
